// File: rtl/ct_had_trace_fifo_if.sv
// Bundled write/read/status signals of the HAD trace FIFO.
// Handshake: wr_vld has no ready; every valid lane is either stored or counted as dropped in
// that cycle. rd_en is a strobe accepted only when not empty; rd_data_vld pulses for exactly
// one cycle when rd_data was updated by an accepted read.
interface ct_had_trace_fifo_if #(
  parameter int WIDTH = 64,
  parameter int LANES = 3,
  parameter int PTR_W = 4
);
  logic [LANES-1:0]       wr_vld;
  logic [LANES*WIDTH-1:0] wr_data;
  logic                   mode_wrap;
  logic                   clr;
  logic                   rd_en;
  logic [WIDTH-1:0]       rd_data;
  logic                   rd_data_vld;
  logic [PTR_W:0]         count;
  logic                   empty;
  logic                   full;
  logic                   ovf;
  logic [15:0]            drop_cnt;

  modport master (
    output wr_vld, wr_data, mode_wrap, clr, rd_en,
    input  rd_data, rd_data_vld, count, empty, full, ovf, drop_cnt
  );

  modport slave (
    input  wr_vld, wr_data, mode_wrap, clr, rd_en,
    output rd_data, rd_data_vld, count, empty, full, ovf, drop_cnt
  );
endinterface

// File: rtl/ct_had_trace_fifo.sv
// Multi-lane trace FIFO: compacts up to LANES valid words per cycle, drains one per read strobe,
// with stop-on-full or overwrite-oldest modes, overflow flag and saturating drop counter.
module ct_had_trace_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int LANES = 3,
  parameter int PTR_W = 4
) (
  input  logic                 cpuclk,
  input  logic                 cpurst_b,
  ct_had_trace_fifo_if.slave   bus
);

  logic [PTR_W:0]   r_wptr;
  logic [PTR_W:0]   r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_vld;
  logic             r_ovf;
  logic [15:0]      r_drop_cnt;

  logic [PTR_W:0]   w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_rd_acc;
  logic [PTR_W:0]   w_n;
  logic [PTR_W:0]   w_free;
  logic [PTR_W:0]   w_acc;
  logic [PTR_W:0]   w_ovr;
  logic [PTR_W:0]   w_drop;
  logic [PTR_W:0]   w_rank [LANES];
  logic [PTR_W-1:0] w_widx [LANES];
  logic [16:0]      w_drop_sum;
  logic [15:0]      w_drop_next;

  assign w_count  = r_wptr - r_rptr;
  assign w_empty  = (w_count == '0);
  assign w_full   = (w_count == (PTR_W+1)'(DEPTH));
  assign w_rd_acc = bus.rd_en & ~w_empty;

  // Rank of each valid lane among the set lanes below it gives its compacted slot offset.
  always_comb begin
    w_n = '0;
    for (int k = 0; k < LANES; k++) begin
      w_rank[k] = w_n;
      w_widx[k] = r_wptr[PTR_W-1:0] + w_n[PTR_W-1:0];
      w_n       = w_n + (PTR_W+1)'(bus.wr_vld[k]);
    end
  end

  // The read is applied before the write, so an accepted read frees one slot this cycle.
  always_comb begin
    w_free = (PTR_W+1)'(DEPTH) - w_count + (PTR_W+1)'(w_rd_acc);
    w_acc  = w_n;
    w_ovr  = '0;
    w_drop = '0;
    if (bus.mode_wrap) begin
      if (w_n > w_free) w_ovr = w_n - w_free;
    end else begin
      if (w_n > w_free) w_acc = w_free;
      w_drop = w_n - w_acc;
    end
  end

  assign w_drop_sum  = {1'b0, r_drop_cnt} + 17'(w_drop);
  assign w_drop_next = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_rd_data  <= '0;
      r_rd_vld   <= 1'b0;
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (bus.clr) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_rd_vld   <= 1'b0;
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_rd_vld <= w_rd_acc;
      if (w_rd_acc) r_rd_data <= r_mem[r_rptr[PTR_W-1:0]];
      r_wptr     <= r_wptr + w_acc;
      r_rptr     <= r_rptr + (PTR_W+1)'(w_rd_acc) + w_ovr;
      if (w_ovr != '0) r_ovf <= 1'b1;
      r_drop_cnt <= w_drop_next;
    end
  end

  // Entry storage carries no reset; lanes beyond the accepted count are discarded in stop mode.
  always_ff @(posedge cpuclk) begin
    if (!bus.clr) begin
      for (int k = 0; k < LANES; k++) begin
        if (bus.wr_vld[k] && (w_rank[k] < w_acc))
          r_mem[w_widx[k]] <= bus.wr_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.rd_data     = r_rd_data;
  assign bus.rd_data_vld = r_rd_vld;
  assign bus.count       = w_count;
  assign bus.empty       = w_empty;
  assign bus.full        = w_full;
  assign bus.ovf         = r_ovf;
  assign bus.drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_ct_had_trace_fifo.sv
// Directed bench for ct_had_trace_fifo (DEPTH=16, LANES=3, WIDTH=64) with immediate-assertion checks.
module tb_ct_had_trace_fifo;

  localparam int WIDTH = 64;
  localparam int DEPTH = 16;
  localparam int LANES = 3;
  localparam int PTR_W = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ct_had_trace_fifo_if #(.WIDTH(WIDTH), .LANES(LANES), .PTR_W(PTR_W)) bus ();

  ct_had_trace_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES), .PTR_W(PTR_W)) dut (
    .cpuclk   (clk),
    .cpurst_b (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] vld, input logic [63:0] d0, input logic [63:0] d1,
                      input logic [63:0] d2, input logic mode);
    bus.wr_vld    = vld;
    bus.wr_data   = {d2, d1, d0};
    bus.mode_wrap = mode;
    cycle();
    bus.wr_vld    = '0;
  endtask

  // Writes num sequential words base, base+1, ... three lanes at a time.
  task automatic fill(input logic [63:0] base, input int num, input logic mode);
    for (int i = 0; i < num; i += 3) begin
      int lanes;
      lanes = (num - i) < 3 ? (num - i) : 3;
      push(3'((1 << lanes) - 1), base + 64'(i), base + 64'(i + 1), base + 64'(i + 2), mode);
    end
  endtask

  task automatic pop(input string tag, input logic [63:0] exp);
    bus.rd_en = 1'b1;
    cycle();
    bus.rd_en = 1'b0;
    chk({tag, "_data"}, bus.rd_data, exp);
    chk({tag, "_vld"}, 64'(bus.rd_data_vld), 64'd1);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.wr_vld    = '0;
    bus.wr_data   = '0;
    bus.mode_wrap = 1'b0;
    bus.clr       = 1'b0;
    bus.rd_en     = 1'b0;
    #2;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_full",  64'(bus.full), 64'd0);
    chk("rst_ovf",   64'(bus.ovf), 64'd0);
    chk("rst_drop",  64'(bus.drop_cnt), 64'd0);
    chk("rst_vld",   64'(bus.rd_data_vld), 64'd0);
    chk("rst_data",  bus.rd_data, 64'd0);
    cycle();
    rst_n = 1'b1;
    cycle();

    // 1: sparse lane mask compacts A,C into consecutive entries
    push(3'b101, 64'hA, 64'hB, 64'hC, 1'b0);
    chk("t1_count", 64'(bus.count), 64'd2);
    pop("t1_rd0", 64'hA);
    pop("t1_rd1", 64'hC);
    cycle();
    chk("t1_vld_low", 64'(bus.rd_data_vld), 64'd0);
    chk("t1_empty", 64'(bus.empty), 64'd1);

    // 2: stop mode, only one slot left for three lanes
    fill(64'd0, 15, 1'b0);
    chk("t2_count15", 64'(bus.count), 64'd15);
    push(3'b111, 64'h1111, 64'h2222, 64'h3333, 1'b0);
    chk("t2_count", 64'(bus.count), 64'd16);
    chk("t2_full",  64'(bus.full), 64'd1);
    chk("t2_drop",  64'(bus.drop_cnt), 64'd2);
    chk("t2_ovf",   64'(bus.ovf), 64'd0);
    for (int i = 0; i < 15; i++) pop("t2_rd", 64'(i));
    pop("t2_rdx", 64'h1111);
    chk("t2_empty", 64'(bus.empty), 64'd1);

    // 3: wrap mode overwrites the three oldest entries
    fill(64'd0, 16, 1'b1);
    chk("t3_count16", 64'(bus.count), 64'd16);
    chk("t3_ovf0", 64'(bus.ovf), 64'd0);
    push(3'b111, 64'h1111, 64'h2222, 64'h3333, 1'b1);
    chk("t3_count", 64'(bus.count), 64'd16);
    chk("t3_ovf1",  64'(bus.ovf), 64'd1);
    for (int i = 3; i < 16; i++) pop("t3_rd", 64'(i));
    pop("t3_rdx", 64'h1111);
    pop("t3_rdy", 64'h2222);
    pop("t3_rdz", 64'h3333);
    chk("t3_empty", 64'(bus.empty), 64'd1);
    chk("t3_drop", 64'(bus.drop_cnt), 64'd2);

    // 4: full, simultaneous read and one-lane write in stop mode
    fill(64'd100, 16, 1'b0);
    chk("t4_full", 64'(bus.full), 64'd1);
    bus.rd_en = 1'b1;
    push(3'b010, 64'h0, 64'h7777, 64'h0, 1'b0);
    bus.rd_en = 1'b0;
    chk("t4_rd_data", bus.rd_data, 64'd100);
    chk("t4_rd_vld", 64'(bus.rd_data_vld), 64'd1);
    chk("t4_count", 64'(bus.count), 64'd16);
    chk("t4_drop", 64'(bus.drop_cnt), 64'd2);
    for (int i = 101; i < 116; i++) pop("t4_rd", 64'(i));
    pop("t4_rdw", 64'h7777);

    // 5: read while empty, then clear with concurrent write/read
    bus.rd_en = 1'b1;
    cycle();
    bus.rd_en = 1'b0;
    chk("t5_vld", 64'(bus.rd_data_vld), 64'd0);
    chk("t5_hold", bus.rd_data, 64'h7777);
    chk("t5_count", 64'(bus.count), 64'd0);
    bus.clr   = 1'b1;
    bus.rd_en = 1'b1;
    push(3'b111, 64'h1, 64'h2, 64'h3, 1'b0);
    bus.clr   = 1'b0;
    bus.rd_en = 1'b0;
    chk("t5_clr_count", 64'(bus.count), 64'd0);
    chk("t5_clr_ovf",   64'(bus.ovf), 64'd0);
    chk("t5_clr_drop",  64'(bus.drop_cnt), 64'd0);
    chk("t5_clr_vld",   64'(bus.rd_data_vld), 64'd0);
    chk("t5_clr_data",  bus.rd_data, 64'h7777);

    // 6: wrap bit toggles after 16 pops; then drop counter saturation
    fill(64'd200, 16, 1'b0);
    for (int i = 0; i < 16; i++) pop("t6_rd", 64'(200 + i));
    chk("t6_empty", 64'(bus.empty), 64'd1);
    fill(64'd300, 16, 1'b0);
    chk("t6_wrap_full", 64'(bus.full), 64'd1);
    chk("t6_wrap_count", 64'(bus.count), 64'd16);
    bus.wr_vld    = 3'b111;
    bus.wr_data   = {64'hDEAD, 64'hBEEF, 64'hCAFE};
    bus.mode_wrap = 1'b0;
    for (int i = 0; i < 100; i++) cycle();
    chk("t6_drop300", 64'(bus.drop_cnt), 64'd300);
    for (int i = 0; i < 21745; i++) cycle();
    chk("t6_drop_max", 64'(bus.drop_cnt), 64'hFFFF);
    cycle();
    chk("t6_drop_sat", 64'(bus.drop_cnt), 64'hFFFF);
    bus.wr_vld = '0;
    chk("t6_count", 64'(bus.count), 64'd16);
    chk("t6_ovf", 64'(bus.ovf), 64'd0);
    pop("t6_rd_first", 64'd300);

    // Async reset mid-operation
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_count", 64'(bus.count), 64'd0);
    chk("ar_drop", 64'(bus.drop_cnt), 64'd0);
    chk("ar_data", bus.rd_data, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
